// File: rtl/cast_chain_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cast_seq_pkg
// Shared types and sizing for the cast chain sequencer.
//   WIDTH      maximum packed value width in bits
//   MAX_STEPS  maximum number of cast steps per chain
//   WW         width-field size, $clog2(WIDTH+1)
//   SW         step-count field size, $clog2(MAX_STEPS+1)
//   cast_op_e  3-bit cast opcode
//   state_e    sequencer FSM state encodings
//   cast_val_t packed 4-state value: bits, X/Z mask, width, signedness
// The sizing lives here because cast_val_t is shared by every file that
// imports the package; change it here and everything follows.
// -----------------------------------------------------------------------------
package cast_seq_pkg;

    localparam int WIDTH     = 32;
    localparam int MAX_STEPS = 4;
    localparam int WW        = $clog2(WIDTH + 1);
    localparam int SW        = $clog2(MAX_STEPS + 1);
    localparam int OPW       = 3;

    typedef enum logic [OPW-1:0] {
        OP_END       = 3'd0,
        OP_BOOL      = 3'd1,
        OP_RANGE     = 3'd2,
        OP_DOM2      = 3'd3,
        OP_DOM4      = 3'd4,
        OP_TRANSMUTE = 3'd5,
        OP_SIGN      = 3'd6,
        OP_RSVD      = 3'd7
    } cast_op_e;

    // Encodings match the S_* constants used for the state register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] xmask;
        logic [WW-1:0]    width;
        logic             is_signed;
    } cast_val_t;

    // Over-long programs run MAX_STEPS steps rather than being rejected.
    function automatic logic [SW-1:0] clamp_len(input logic [SW-1:0] len);
        return (len > SW'(MAX_STEPS)) ? SW'(MAX_STEPS) : len;
    endfunction

endpackage

// File: rtl/cast_chain_sequencer_if.sv
// -----------------------------------------------------------------------------
// cast_seq_if
// Request / program / result bundle of the cast chain sequencer.
//   in_*    request handshake and source value (requester -> sequencer)
//   prog_*  chain program: length, ops and args, step 0 in the LSBs
//   out_*   result handshake and result value (sequencer -> requester)
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface cast_seq_if;
    import cast_seq_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_value;
    logic [WIDTH-1:0]         in_xmask;
    logic [WW-1:0]            in_width;
    logic                     in_signed;
    logic [SW-1:0]            prog_len;
    logic [MAX_STEPS*OPW-1:0] prog_op;
    logic [MAX_STEPS*WW-1:0]  prog_arg;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_value;
    logic [WIDTH-1:0]         out_xmask;
    logic [WW-1:0]            out_width;
    logic                     out_signed;
    logic [SW-1:0]            out_steps;
    logic                     out_err;

    modport master (
        output in_valid, in_value, in_xmask, in_width, in_signed,
               prog_len, prog_op, prog_arg, out_ready,
        input  in_ready, out_valid, out_value, out_xmask, out_width,
               out_signed, out_steps, out_err
    );

    modport slave (
        input  in_valid, in_value, in_xmask, in_width, in_signed,
               prog_len, prog_op, prog_arg, out_ready,
        output in_ready, out_valid, out_value, out_xmask, out_width,
               out_signed, out_steps, out_err
    );

endinterface

// File: rtl/cast_chain_sequencer_step_unit.sv
// -----------------------------------------------------------------------------
// cast_step_unit
// Purely combinational single cast step, time-shared by the sequencer.
//   val_i  working value before the step
//   op_i   cast opcode
//   arg_i  step argument (target width for RANGE/TRANSMUTE, sign for SIGN)
//   val_o  working value after the step (equals val_i when err_o is set)
//   err_o  step is illegal
// Relies on bits at and above val_i.width being 0 and preserves that.
// -----------------------------------------------------------------------------
module cast_step_unit
    import cast_seq_pkg::*;
(
    input  cast_val_t        val_i,
    input  cast_op_e         op_i,
    input  logic [WW-1:0]    arg_i,
    output cast_val_t        val_o,
    output logic             err_o
);

    logic [WIDTH-1:0] arg_mask;    // bits below arg_i
    logic [WIDTH-1:0] width_mask;  // bits below current width
    logic [WIDTH-1:0] msb_sel;     // one-hot at bit width-1 (0 if width==0)
    logic [WIDTH-1:0] ext_mask;    // bits gained when widening
    logic             val_msb;
    logic             x_msb;
    logic             known_one;
    logic             any_x;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign arg_mask[gi]   = (WW'(gi) < arg_i);
            assign width_mask[gi] = (WW'(gi) < val_i.width);
        end
    endgenerate

    assign msb_sel   = width_mask & ~(width_mask >> 1);
    assign ext_mask  = arg_mask & ~width_mask;
    assign val_msb   = |(val_i.value & msb_sel);
    assign x_msb     = |(val_i.xmask & msb_sel);
    assign known_one = |(val_i.value & ~val_i.xmask);
    assign any_x     = |val_i.xmask;

    always_comb begin
        val_o = val_i;
        err_o = 1'b0;
        case (op_i)
            OP_END: begin
                // the sequencer stops on END; data passes through
            end
            OP_BOOL: begin
                val_o.value     = {{(WIDTH-1){1'b0}}, known_one};
                val_o.xmask     = {{(WIDTH-1){1'b0}}, ~known_one & any_x};
                val_o.width     = WW'(1);
                val_o.is_signed = 1'b0;
            end
            OP_RANGE: begin
                if (arg_i == '0 || arg_i > WW'(WIDTH)) begin
                    err_o = 1'b1;
                end else begin
                    // Truncation and extension in one expression: ext_mask
                    // is empty when narrowing, arg_mask clips when narrowing.
                    val_o.value = (val_i.value & arg_mask) |
                                  ((val_i.is_signed && val_msb) ? ext_mask : '0);
                    val_o.xmask = (val_i.xmask & arg_mask) |
                                  ((val_i.is_signed && x_msb) ? ext_mask : '0);
                    val_o.width = arg_i;
                end
            end
            OP_DOM2: begin
                val_o.value = val_i.value & ~val_i.xmask;
                val_o.xmask = '0;
            end
            OP_DOM4: begin
                // legal no-op
            end
            OP_TRANSMUTE: begin
                if (arg_i != val_i.width) begin
                    err_o = 1'b1;
                end
            end
            OP_SIGN: begin
                val_o.is_signed = arg_i[0];
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
        if (err_o) begin
            val_o = val_i;
        end
    end

endmodule

// File: rtl/cast_chain_sequencer.sv
// -----------------------------------------------------------------------------
// cast_chain_sequencer
// Applies a programmed chain of up to MAX_STEPS casts to a 4-state packed
// value, one step per clock, between request and result handshakes.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cast_seq_if.slave: in_* request, prog_* program, out_* result
// Flow: IDLE accepts a request, RUN executes one step per cycle through the
// shared cast_step_unit, DONE presents the result until out_ready.
// -----------------------------------------------------------------------------
module cast_chain_sequencer
    import cast_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    cast_seq_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [SW-1:0]            step_q,  step_d;
    logic [SW-1:0]            len_q,   len_d;
    logic [MAX_STEPS*OPW-1:0] ops_q,   ops_d;
    logic [MAX_STEPS*WW-1:0]  args_q,  args_d;
    cast_val_t                work_q,  work_d;
    logic                     err_q,   err_d;

    cast_op_e                 cur_op;
    logic [WW-1:0]            cur_arg;
    cast_val_t                step_val;
    logic                     step_err;
    logic [SW-1:0]            req_len;
    logic [WIDTH-1:0]         in_mask;

    // Source bits above in_width are cleared on accept so the working value
    // starts out honouring the zero-above-width invariant.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_in_mask
            assign in_mask[gi] = (WW'(gi) < bus.in_width);
        end
    endgenerate

    assign req_len = clamp_len(bus.prog_len);
    // step_q stays below len_q (<= MAX_STEPS) while in RUN, so these selects
    // never leave the program vectors.
    assign cur_op  = cast_op_e'(ops_q[step_q*OPW +: OPW]);
    assign cur_arg = args_q[step_q*WW +: WW];

    cast_step_unit u_step (
        .val_i (work_q),
        .op_i  (cur_op),
        .arg_i (cur_arg),
        .val_o (step_val),
        .err_o (step_err)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        ops_d   = ops_q;
        args_d  = args_q;
        work_d  = work_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d.value     = bus.in_value & in_mask;
                    work_d.xmask     = bus.in_xmask & in_mask;
                    work_d.width     = bus.in_width;
                    work_d.is_signed = bus.in_signed;
                    ops_d            = bus.prog_op;
                    args_d           = bus.prog_arg;
                    len_d            = req_len;
                    step_d           = '0;
                    err_d            = 1'b0;
                    state_d          = (req_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cur_op == OP_END) begin
                    state_d = S_DONE;
                end else if (step_err) begin
                    // failing step leaves data and step count untouched
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    work_d = step_val;
                    step_d = step_q + 1'b1;
                    if (step_q == len_q - 1'b1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            len_q   <= '0;
            ops_q   <= '0;
            args_q  <= '0;
            work_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            ops_q   <= ops_d;
            args_q  <= args_d;
            work_q  <= work_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from the working registers; they only change in
    // IDLE/RUN, so they are stable for the whole of DONE.
    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_value  = work_q.value;
    assign bus.out_xmask  = work_q.xmask;
    assign bus.out_width  = work_q.width;
    assign bus.out_signed = work_q.is_signed;
    assign bus.out_steps  = step_q;
    assign bus.out_err    = err_q;

endmodule
